uart_inst_receiver: RTL and testbench

Serial front end that feeds the processor its instruction stream. It deserialises 8N1 UART bytes from the host pin and assembles four bytes, little-endian, into a 32-bit instruction word. It presents each word to the cpu through a one-deep valid/ready holding register. It sits directly upstream of the cpu in the top-level design, on the same divided `clk` domain as the cpu and memories.

---
 rtl/uart_inst_receiver.sv | 182 ++++++++++++++++++
 tb/tb_uart_inst_receiver.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_inst_receiver.sv
// 8N1 UART receiver assembling four little-endian bytes into a 32-bit instruction word; optional idle timeout via UART_INST_TIMEOUT_EN.
// Latency: inst_valid rises the cycle after the fourth byte's stop-bit sample (rx passes a 2-flop synchroniser first).
// Backpressure: one-deep valid/ready holding register; a word completing while it is still full is dropped and flagged on overflow.
module uart_inst_receiver #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        frame_err,
    output logic        overflow,
    output logic        busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_bad_cfg
        $error("uart_inst_receiver: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rx_meta;
    logic        rx_s;
    logic [CW-1:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_word;
    logic        half_hit;
    logic        full_hit;
    logic        data_smp;
    logic        stop_smp;
    logic        word_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign half_hit = (bit_cnt == CW'(HALF_BIT - 1));
    assign full_hit = (bit_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!rx_s) state_nxt = S_START;
            S_START: if (half_hit) state_nxt = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (full_hit && bit_idx == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (full_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        data_smp = (state == S_DATA) && full_hit;
        stop_smp = (state == S_STOP) && full_hit;
    end

    assign word_done = stop_smp && rx_s && (byte_cnt == 2'd3);

    // Bit timer restarts at every sample point so DATA/STOP samples stay centred.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (state == S_IDLE || (state == S_START ? half_hit : full_hit)) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == S_START) begin
                bit_idx <= '0;
            end else if (data_smp) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (data_smp) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
            end
        end
    end

`ifdef UART_INST_TIMEOUT_EN
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW        = $clog2(TO_CYCLES);

    logic [TW-1:0] idle_cnt;
    logic          idle_expired;

    // A start bit seen on the expiry cycle wins, so a late byte is never discarded.
    assign idle_expired = (state == S_IDLE) && rx_s && (byte_cnt != 2'd0) &&
                          (idle_cnt == TW'(TO_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state != S_IDLE || !rx_s || byte_cnt == 2'd0 || idle_expired) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt  <= '0;
            asm_word  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_smp && !rx_s;
            if (stop_smp) begin
                if (rx_s) begin
                    case (byte_cnt)
                        2'd0:    asm_word[7:0]   <= shift_reg;
                        2'd1:    asm_word[15:8]  <= shift_reg;
                        2'd2:    asm_word[23:16] <= shift_reg;
                        default: ;
                    endcase
                    byte_cnt <= byte_cnt + 1'b1;
                end else begin
                    byte_cnt <= 2'd0;
                end
            end
`ifdef UART_INST_TIMEOUT_EN
            else if (idle_expired) begin
                byte_cnt <= 2'd0;
            end
`endif
        end
    end

    // Lane 3 goes straight from the shift register into the holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_out   <= '0;
            inst_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (word_done) begin
                if (!inst_valid || inst_ready) begin
                    inst_out   <= {shift_reg, asm_word};
                    inst_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (inst_valid && inst_ready) begin
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_inst_receiver.sv
// Randomised bench for uart_inst_receiver: frames are scheduled as byte events and checked
// every cycle against a word-level model of the assembly and holding-register rules.
module tb_uart_inst_receiver;

    localparam int CPB    = 4;
    localparam int TOB    = 40;
    localparam int HALF   = CPB / 2;
    localparam int TO_CYC = TOB * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        frame_err;
    logic        overflow;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rmode = 0;
    bit checking = 1'b0;

    // Byte events: edge at which the stop bit is judged, plus the frame's start-detect edge.
    int          ev_q[$];
    int          st_q[$];
    logic [7:0]  b_q[$];
    bit          g_q[$];

    bit          m_valid = 1'b0;
    logic [31:0] m_out = '0;
    bit          m_ferr = 1'b0;
    bit          m_ovf = 1'b0;
    int          m_bcnt = 0;
    logic [31:0] m_word = '0;
    int          last_ev = 0;

    int vhi_n = 0;
    int ovf_n = 0;
    int fe_n = 0;

    uart_inst_receiver #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .inst_out  (inst_out),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .frame_err (frame_err),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        bit hs;
        bit done;
        bit good;
        logic [7:0] b;
        int st;
        cyc = cyc + 1;
        hs = m_valid && inst_ready;
        done = 1'b0;
        m_ferr = 1'b0;
        m_ovf = 1'b0;
        if (reset) begin
            m_valid = 1'b0;
            m_out = '0;
            m_bcnt = 0;
            m_word = '0;
            ev_q.delete();
            st_q.delete();
            b_q.delete();
            g_q.delete();
        end else begin
            if (ev_q.size() > 0 && ev_q[0] == cyc) begin
                void'(ev_q.pop_front());
                st = st_q.pop_front();
                b = b_q.pop_front();
                good = g_q.pop_front();
`ifdef UART_INST_TIMEOUT_EN
                if (m_bcnt != 0 && st - last_ev > TO_CYC) m_bcnt = 0;
`else
                if (st < 0) m_bcnt = 0;
`endif
                if (good) begin
                    m_word[8*m_bcnt +: 8] = b;
                    done = (m_bcnt == 3);
                    m_bcnt = (m_bcnt + 1) % 4;
                    last_ev = cyc;
                end else begin
                    m_ferr = 1'b1;
                    m_bcnt = 0;
                end
            end
            if (done) begin
                if (!m_valid || inst_ready) begin
                    m_out = m_word;
                    m_valid = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking && !reset) begin
            chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
            chk("inst_out", inst_out, m_out);
            chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            if (inst_valid) vhi_n++;
            if (overflow) ovf_n++;
            if (frame_err) fe_n++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0:       inst_ready = 1'b0;
                1:       inst_ready = 1'b1;
                default: inst_ready = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit good, input int gap);
        int e0;
        e0 = cyc;
        ev_q.push_back(e0 + 3 + HALF + 9 * CPB);
        st_q.push_back(e0 + 3);
        b_q.push_back(b);
        g_q.push_back(good);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = good;
        tick(CPB);
        rx = 1'b1;
        tick(good ? gap : gap + 2 * CPB + 2);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8], 1'b1, 1);
    endtask

    initial begin
        logic [7:0] rb;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checking = 1'b1;

        // Idle after reset
        tick(200);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_valid", {31'd0, inst_valid}, 32'd0);
        chk("idle_out", inst_out, 32'd0);
        chk("idle_ferr", {31'd0, frame_err}, 32'd0);
        chk("idle_ovf", {31'd0, overflow}, 32'd0);

        // One word, cpu always ready
        rmode = 1;
        vhi_n = 0;
        send_word(32'h0010_0513);
        tick(4);
        chk("addi_valid_cycles", vhi_n, 32'd1);
        chk("addi_word", inst_out, 32'h0010_0513);
        chk("addi_model", m_out, 32'h0010_0513);

        // Held word, second word dropped
        rmode = 0;
        ovf_n = 0;
        send_word(32'hDEAD_BEEF);
        send_word(32'h0000_0013);
        tick(4);
        chk("ovf_pulses", ovf_n, 32'd1);
        chk("ovf_held_word", inst_out, 32'hDEAD_BEEF);
        chk("ovf_held_valid", {31'd0, inst_valid}, 32'd1);
        rmode = 1;
        tick(2);
        chk("ovf_drain_valid", {31'd0, inst_valid}, 32'd0);

        // Glitch between bytes of a word
        fe_n = 0;
        send(8'h11, 1'b1, 2);
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(6);
        chk("glitch_busy", {31'd0, busy}, 32'd0);
        chk("glitch_ferr", fe_n, 32'd0);
        send(8'h22, 1'b1, 1);
        send(8'h33, 1'b1, 1);
        send(8'h44, 1'b1, 1);
        tick(4);
        chk("glitch_word", inst_out, 32'h4433_2211);

        // Framing error resynchronises the word
        fe_n = 0;
        send(8'h77, 1'b1, 1);
        send(8'h88, 1'b1, 1);
        send(8'hAA, 1'b0, 2);
        send_word(32'h0403_0201);
        tick(4);
        chk("ferr_pulses", fe_n, 32'd1);
        chk("ferr_word", inst_out, 32'h0403_0201);
        chk("ferr_model", m_out, 32'h0403_0201);

        // Long idle inside a word
        send(8'h55, 1'b1, 1);
        send(8'h66, 1'b1, 1);
        tick(200);
        send_word(32'h4433_2211);
        tick(4);
`ifdef UART_INST_TIMEOUT_EN
        chk("timeout_word", inst_out, 32'h4433_2211);
`else
        chk("no_timeout_word", inst_out, 32'h2211_6655);
`endif

        // Reset in the middle of a frame
        rx = 1'b0;
        tick(10);
        chk("midframe_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_out", inst_out, 32'd0);
        tick(2);
        rx = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(5);
        send_word(32'hD4C3_B2A1);
        tick(4);
        chk("post_reset_word", inst_out, 32'hD4C3_B2A1);

        // Random bytes, stop errors, gaps and cpu stalls
        for (int n = 0; n < 60; n++) begin
            rb = 8'($urandom);
            rmode = $urandom_range(0, 2);
            send(rb, $urandom_range(0, 9) != 0, $urandom_range(0, 3));
        end
        tick(60);
        rmode = 1;
        tick(10);
        chk("final_drained", {31'd0, inst_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
